// File: rtl/led_status_arbiter.sv
// -----------------------------------------------------------------------------
// led_status_arbiter
//   Shares one active-low RGB LED between NUM_REQ status sources. Index 0 has
//   the highest priority. An owner keeps the LED for at least MIN_HOLD ticks
//   before a higher-priority source may take it, and every change of owner is
//   separated by GAP_TICKS blank ticks. A source may ask for its colour to
//   blink, toggling once per tick. An internal divider produces the tick, so
//   all timing parameters are in ticks.
//
// Ports
//   clock   in   1            system clock
//   reset   in   1            synchronous, active-high reset
//   req     in   NUM_REQ      level request per source
//   color   in   3*NUM_REQ    per-source colour {b,g,r}; [3i+2:3i] is source i
//   blink   in   NUM_REQ      1 = source i blinks, 0 = steady
//   grant   out  NUM_REQ      one-hot current owner, zero when none
//   busy    out  1            high while showing or in the blank gap
//   tick    out  1            one-cycle pulse every TICK_DIV clocks
//   led_r   out  1            red,   active low
//   led_g   out  1            green, active low
//   led_b   out  1            blue,  active low
// -----------------------------------------------------------------------------
module led_status_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TICK_DIV  = 12_000_000,
  parameter int MIN_HOLD  = 2,
  parameter int GAP_TICKS = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   color,
  input  logic [NUM_REQ-1:0]     blink,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   tick,
  output logic                   led_r,
  output logic                   led_g,
  output logic                   led_b
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div;
  logic [HOLD_W-1:0]   hold;
  logic [GAP_W-1:0]    gap;
  logic                phase;
  logic [2:0]          own_color;
  logic [2:0]          led_n;      // {b,g,r}, active low

  // ---------------------------------------------------------------------------
  // Tick divider: tick is registered, so it is high for the cycle that follows
  // the edge on which div sat at its terminal count.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so that every register
  // samples the pre-edge value of every other register, whatever the order of
  // statements inside the block.
  always_ff @(posedge clock) begin
    if (reset) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (div == DIV_W'(TICK_DIV - 1));
      if (div == DIV_W'(TICK_DIV - 1)) div <= '0;
      else                             div <= div + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration terms
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] win_onehot;
  logic [2:0]         win_color;
  logic               owner_req;
  logic               owner_blink;
  logic               lower_req;
  logic               hold_done;

  // Isolating the lowest set bit gives the fixed-priority winner directly.
  assign win_onehot  = req & (~req + NUM_REQ'(1));
  assign owner_req   = |(req & grant);
  assign owner_blink = |(blink & grant);
  // grant - 1 is a mask of every index strictly below the (one-hot) owner.
  assign lower_req   = |(req & (grant - NUM_REQ'(1)));
  assign hold_done   = (int'(hold) + 1) >= MIN_HOLD;

  // NOTE: every signal written in always_comb gets a default before any
  // conditional assignment, so no path can leave it holding a value (latch).
  always_comb begin
    win_color = 3'b000;
    // Descending scan: the last hit is the lowest set index.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_color = color[3*i +: 3];
    end
  end

  // ---------------------------------------------------------------------------
  // Ownership FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      hold      <= '0;
      gap       <= '0;
      phase     <= 1'b0;
      own_color <= 3'b000;
      led_n     <= 3'b111;
    end else begin
      case (state)
        IDLE: begin
          // Not tick-gated: a request is granted on the very next edge.
          if (|req) begin
            state     <= SHOW;
            grant     <= win_onehot;
            own_color <= win_color;
            hold      <= '0;
            phase     <= 1'b1;
            busy      <= 1'b1;
            led_n     <= ~win_color;
          end
        end

        SHOW: begin
          if (tick) begin
            if (!owner_req || (hold_done && lower_req)) begin
              state <= GAP;
              grant <= '0;
              gap   <= '0;
              led_n <= 3'b111;
            end else begin
              if (int'(hold) < MIN_HOLD) hold <= hold + 1'b1;
              if (owner_blink) begin
                phase <= ~phase;
                led_n <= ~(own_color & {3{~phase}});
              end
            end
          end
        end

        GAP: begin
          if (tick) begin
            if ((int'(gap) + 1) >= GAP_TICKS) begin
              if (|req) begin
                state     <= SHOW;
                grant     <= win_onehot;
                own_color <= win_color;
                hold      <= '0;
                phase     <= 1'b1;
                led_n     <= ~win_color;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              gap <= gap + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
          led_n <= 3'b111;
        end
      endcase
    end
  end

  assign led_r = led_n[0];
  assign led_g = led_n[1];
  assign led_b = led_n[2];

endmodule

// File: tb/tb_led_status_arbiter.sv
// -----------------------------------------------------------------------------
// tb_led_status_arbiter
//   Directed bench for led_status_arbiter with TICK_DIV=4, MIN_HOLD=2,
//   GAP_TICKS=1, NUM_REQ=4. k counts rising edges since reset was released;
//   tick is expected high exactly when k is a non-zero multiple of 4, and the
//   FSM acts on the edges where k%4 == 1. All expected values below are
//   worked out by hand from that timeline.
// -----------------------------------------------------------------------------
module tb_led_status_arbiter;

  localparam int NUM_REQ = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [3*NUM_REQ-1:0] color;
  logic [NUM_REQ-1:0]   blink;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 tick;
  logic                 led_r;
  logic                 led_g;
  logic                 led_b;

  int vectors     = 0;
  int miscompares = 0;
  int k           = 0;

  led_status_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .TICK_DIV  (4),
    .MIN_HOLD  (2),
    .GAP_TICKS (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .color (color),
    .blink (blink),
    .grant (grant),
    .busy  (busy),
    .tick  (tick),
    .led_r (led_r),
    .led_g (led_g),
    .led_b (led_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic check_led(input string tag, input logic [2:0] expected_bgr);
    check(tag, {29'd0, led_b, led_g, led_r}, {29'd0, expected_bgr});
  endtask

  // One clock per iteration; outputs are sampled on the falling edge and the
  // tick output is checked against the divider timeline every cycle.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      if (reset) k = 0;
      else       k++;
      @(negedge clock);
      check($sformatf("tick@k%0d", k), {31'd0, tick},
            {31'd0, (!reset && k > 0 && (k % 4) == 0)});
    end
  endtask

  // grant must never have more than one bit set.
  always @(negedge clock) begin
    vectors++;
    assert ($onehot0(grant))
      else begin
        miscompares++;
        $error("FAIL grant_onehot0: observed %b expected at most one bit", grant);
      end
  end

  initial begin
    reset = 1'b1;
    req   = 4'hF;
    color = '0;
    blink = '0;

    // 1: reset held with every request active
    step(3);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check_led("rst_led", 3'b111);

    // 2: single steady owner, colour change while owned is ignored
    reset = 1'b0;
    req   = 4'b0000;
    step(1);                                   // k=1
    check("idle_grant", 32'(grant), 32'h0);
    req        = 4'b0100;
    color[8:6] = 3'b010;
    step(1);                                   // k=2: granted one clock later
    check("s2_grant", 32'(grant), 32'h4);
    check("s2_busy", 32'(busy), 32'h1);
    check_led("s2_led", 3'b101);
    for (int i = 0; i < 40; i++) begin         // k=3..42, ten ticks
      step(1);
      check("s2_grant_hold", 32'(grant), 32'h4);
      check_led("s2_led_hold", 3'b101);
      if (i == 7) color = '1;
    end
    req = 4'b0000;
    step(2);                                   // k=44
    check("s2_before_rel", 32'(grant), 32'h4);
    step(1);                                   // k=45: release into GAP
    check("s2_rel_grant", 32'(grant), 32'h0);
    check("s2_rel_busy", 32'(busy), 32'h1);
    check_led("s2_rel_led", 3'b111);
    step(3);                                   // k=48
    check("s2_gap_busy", 32'(busy), 32'h1);
    step(1);                                   // k=49: back to IDLE
    check("s2_idle_busy", 32'(busy), 32'h0);

    // 3: blinking red owner
    color      = '0;
    color[5:3] = 3'b001;
    blink      = 4'b0010;
    req        = 4'b0010;
    step(1);                                   // k=50
    check("s3_grant", 32'(grant), 32'h2);
    check_led("s3_on0", 3'b110);
    step(2);                                   // k=52
    check_led("s3_on1", 3'b110);
    step(1);                                   // k=53: first toggle
    check_led("s3_off", 3'b111);
    check("s3_grant_blink", 32'(grant), 32'h2);
    step(4);                                   // k=57: second toggle
    check_led("s3_on2", 3'b110);
    req = 4'b0000;
    step(4);                                   // k=61: release
    check("s3_rel_grant", 32'(grant), 32'h0);
    check("s3_rel_busy", 32'(busy), 32'h1);
    check_led("s3_rel_led", 3'b111);
    step(4);                                   // k=65: IDLE
    check("s3_idle_busy", 32'(busy), 32'h0);

    // 4: preemption only after MIN_HOLD ticks
    blink       = '0;
    color       = '0;
    color[11:9] = 3'b100;
    color[2:0]  = 3'b011;
    req         = 4'b1000;
    step(1);                                   // k=66
    check("s4_grant3", 32'(grant), 32'h8);
    check_led("s4_led3", 3'b011);
    req = 4'b1001;
    step(1);                                   // k=67
    check("s4_no_early", 32'(grant), 32'h8);
    step(2);                                   // k=69: first tick, hold=1
    check("s4_tick1", 32'(grant), 32'h8);
    check_led("s4_led3_hold", 3'b011);
    step(3);                                   // k=72
    check("s4_pre_preempt", 32'(grant), 32'h8);
    step(1);                                   // k=73: preempt into GAP
    check("s4_gap_grant", 32'(grant), 32'h0);
    check_led("s4_gap_led", 3'b111);
    step(3);                                   // k=76
    check("s4_gap_hold", 32'(grant), 32'h0);
    step(1);                                   // k=77: source 0 wins
    check("s4_grant0", 32'(grant), 32'h1);
    check_led("s4_led0", 3'b100);

    // 5: grant lands just before a tick; hold still needs two tick edges
    req = 4'b0000;
    step(4);                                   // k=81
    check("s5_rel", 32'(grant), 32'h0);
    step(4);                                   // k=85
    check("s5_idle", 32'(busy), 32'h0);
    step(2);                                   // k=87
    req = 4'b1000;
    step(1);                                   // k=88, tick high now
    check("s5_grant3", 32'(grant), 32'h8);
    req = 4'b1001;
    step(1);                                   // k=89: hold 0->1, stays
    check("s5_hold1", 32'(grant), 32'h8);
    step(3);                                   // k=92
    check("s5_hold2", 32'(grant), 32'h8);
    step(1);                                   // k=93: preempt
    check("s5_gap", 32'(grant), 32'h0);
    step(4);                                   // k=97
    check("s5_grant0", 32'(grant), 32'h1);

    // 6: reset mid-SHOW (on an edge that would otherwise raise tick)
    step(2);                                   // k=99
    reset = 1'b1;
    step(1);
    check("s6_show_rst_grant", 32'(grant), 32'h0);
    check("s6_show_rst_busy", 32'(busy), 32'h0);
    check_led("s6_show_rst_led", 3'b111);
    reset = 1'b0;
    step(1);                                   // k=1, req still 1001
    check("s6_regrant", 32'(grant), 32'h1);
    check("s6_regrant_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    step(3);                                   // k=4
    check("s6_hold", 32'(grant), 32'h1);
    step(1);                                   // k=5: into GAP
    check("s6_gap_grant", 32'(grant), 32'h0);
    check("s6_gap_busy", 32'(busy), 32'h1);
    // reset mid-GAP
    reset = 1'b1;
    step(1);
    check("s6_gap_rst_busy", 32'(busy), 32'h0);
    check("s6_gap_rst_grant", 32'(grant), 32'h0);
    check_led("s6_gap_rst_led", 3'b111);
    reset = 1'b0;
    step(8);                                   // divider restarts: ticks at k=4,8
    check("s6_final_busy", 32'(busy), 32'h0);
    check("s6_final_grant", 32'(grant), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
